// File: rtl/ws2812_ring_display.sv
// WS2812 ring driver: one LED marks the encoder position, coloured by last direction.
// Optional trail LED behind the marker is enabled with `define WS2812_TRAIL_EN.
module ws2812_ring_display #(
    parameter int          LED_BITS     = 4,
    parameter int          T0H          = 5,
    parameter int          T1H          = 10,
    parameter int          T_BIT        = 15,
    parameter int          RESET_CYCLES = 3600,
    parameter logic [23:0] CW_COLOR     = 24'h200000,
    parameter logic [23:0] CCW_COLOR    = 24'h002000,
    parameter logic [23:0] BG_COLOR     = 24'h000000,
    parameter logic [23:0] TRAIL_COLOR  = 24'h000008
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] count,
    input  logic       direction,
    output logic       dout,
    output logic       busy,
    output logic       frame_done
);

    localparam int BTW = $clog2(T_BIT);
    localparam int GTW = $clog2(RESET_CYCLES + 1);

    localparam logic [BTW-1:0]      T0H_M1   = BTW'(T0H - 1);
    localparam logic [BTW-1:0]      T1H_M1   = BTW'(T1H - 1);
    localparam logic [BTW-1:0]      TBIT_M1  = BTW'(T_BIT - 1);
    localparam logic [GTW-1:0]      GAP_M1   = GTW'(RESET_CYCLES - 1);
    localparam logic [LED_BITS-1:0] LED_LAST = '1;

`ifdef WS2812_TRAIL_EN
    localparam bit TRAIL_EN = 1'b1;
`else
    localparam bit TRAIL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {GAP, IDLE, HIGH, LOW} state_t;

    state_t              state_q, state_d;
    logic [GTW-1:0]      gap_q, gap_d;
    logic [BTW-1:0]      tmr_q, tmr_d;
    logic [8:0]          snap_q, snap_d;
    logic                first_q, first_d;
    logic [LED_BITS-1:0] led_q, led_d;
    logic [4:0]          bit_q, bit_d;
    logic [23:0]         color_q, color_d;
    logic                dout_q, dout_d;
    logic                done_q, done_d;

    logic start, hi_last, bit_end, gap_end, last_bit, last_led;

    // Marker wins over the trail when both land on the same LED.
    function automatic logic [23:0] led_color(input logic [LED_BITS-1:0] idx,
                                              input logic [8:0]          snap);
        logic [LED_BITS-1:0] lit;
        logic [LED_BITS-1:0] trail;
        lit   = snap[LED_BITS-1:0];
        trail = snap[8] ? lit - LED_BITS'(1) : lit + LED_BITS'(1);
        if (idx == lit)
            return snap[8] ? CW_COLOR : CCW_COLOR;
        if (TRAIL_EN && idx == trail)
            return TRAIL_COLOR;
        return BG_COLOR;
    endfunction

    assign start    = (state_q == IDLE) && (first_q || ({direction, count} != snap_q));
    assign hi_last  = tmr_q == (color_q[bit_q] ? T1H_M1 : T0H_M1);
    assign bit_end  = tmr_q == TBIT_M1;
    assign gap_end  = gap_q == GAP_M1;
    assign last_bit = bit_q == 5'd0;
    assign last_led = led_q == LED_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GAP;
            gap_q   <= '0;
            tmr_q   <= '0;
            snap_q  <= '0;
            first_q <= 1'b1;
            led_q   <= '0;
            bit_q   <= '0;
            color_q <= '0;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            tmr_q   <= tmr_d;
            snap_q  <= snap_d;
            first_q <= first_d;
            led_q   <= led_d;
            bit_q   <= bit_d;
            color_q <= color_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            GAP:  if (gap_end) state_d = IDLE;
            IDLE: if (start)   state_d = HIGH;
            HIGH: if (hi_last) state_d = LOW;
            LOW:  if (bit_end) state_d = (last_bit && last_led) ? GAP : HIGH;
            default:           state_d = GAP;
        endcase
    end

    // Colour is latched once per LED so the bit shifter never sees a mid-LED change.
    always_comb begin
        gap_d   = gap_q;
        tmr_d   = tmr_q;
        snap_d  = snap_q;
        first_d = first_q;
        led_d   = led_q;
        bit_d   = bit_q;
        color_d = color_q;
        case (state_q)
            GAP: gap_d = gap_end ? '0 : gap_q + GTW'(1);
            IDLE: begin
                if (start) begin
                    snap_d  = {direction, count};
                    first_d = 1'b0;
                    led_d   = '0;
                    bit_d   = 5'd23;
                    tmr_d   = '0;
                    color_d = led_color('0, {direction, count});
                end
            end
            HIGH: tmr_d = tmr_q + BTW'(1);
            LOW: begin
                if (bit_end) begin
                    tmr_d = '0;
                    if (last_bit) begin
                        bit_d   = 5'd23;
                        led_d   = led_q + LED_BITS'(1);
                        color_d = led_color(led_q + LED_BITS'(1), snap_q);
                        if (last_led) gap_d = '0;
                    end else begin
                        bit_d = bit_q - 5'd1;
                    end
                end else begin
                    tmr_d = tmr_q + BTW'(1);
                end
            end
            default: ;
        endcase
    end

    // Post-reset gap is not a frame end, so first_q masks its pulse.
    always_comb begin
        dout_d     = (state_d == HIGH);
        done_d     = (state_q == GAP) && gap_end && !first_q;
        busy       = (state_q != IDLE);
        dout       = dout_q;
        frame_done = done_q;
    end

endmodule

// File: tb/tb_ws2812_ring_display.sv
// Directed bench for ws2812_ring_display: decodes whole frames from dout and checks timing.
module tb_ws2812_ring_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] count;
    logic       direction;
    logic       dout, busy, frame_done;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [23:0] cap [16];

    ws2812_ring_display dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .direction  (direction),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] other_exp(input int i, input logic [7:0] cnt, input logic d);
`ifdef WS2812_TRAIL_EN
        logic [3:0] t;
        t = d ? cnt[3:0] - 4'd1 : cnt[3:0] + 4'd1;
        if (i == int'(t)) return 24'h000008;
`endif
        return 24'h000000;
    endfunction

    // From a gap-start negedge, count low cycles until dout rises.
    task automatic wait_rise(output int zeros, output int busy_lo, output int done_seen);
        zeros = 0; busy_lo = 0; done_seen = 0;
        @(negedge clk);
        while (dout !== 1'b1 && zeros < 20000) begin
            if (busy !== 1'b1) busy_lo++;
            if (frame_done === 1'b1) done_seen++;
            zeros++;
            @(negedge clk);
        end
    endtask

    // Entered at the negedge where the first bit's high is visible.
    task automatic capture(output int bad);
        bad = 0;
        for (int b = 0; b < 384; b++) begin
            int hi, lo;
            hi = 0; lo = 0;
            while (dout === 1'b1 && hi < 40) begin hi++; @(negedge clk); end
            while (dout !== 1'b1 && lo < 40 && !(b == 383 && hi + lo == 15)) begin
                lo++; @(negedge clk);
            end
            if (!(hi == 5 || hi == 10) || hi + lo != 15) bad++;
            cap[b/24] = {cap[b/24][22:0], hi > 7};
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cnt, input logic d,
                             input logic [23:0] lit_exp);
        int s, bad, wrong, n;
        s = cyc;
        capture(bad);
        chk({tag, " timing"}, bad, 0);
        chk({tag, " lit"}, cap[cnt[3:0]], lit_exp);
        wrong = 0;
        for (int i = 0; i < 16; i++)
            if (i != int'(cnt[3:0]) && cap[i] !== other_exp(i, cnt, d)) wrong++;
        chk({tag, " others"}, wrong, 0);
        n = 0;
        while (frame_done !== 1'b1 && n < 5000) begin n++; @(negedge clk); end
        chk({tag, " done latency"}, cyc - s, 9360);
        @(negedge clk);
        chk({tag, " done width"}, frame_done, 1'b0);
    endtask

    initial begin
        int zeros, blo, dn, act;
        rst = 1'b1; count = 8'd0; direction = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst dout", dout, 1'b0);
        chk("rst busy", busy, 1'b1);
        chk("rst done", frame_done, 1'b0);
        rst = 1'b0;

        wait_rise(zeros, blo, dn);
        chk("post-reset gap", zeros, 3600);
        chk("post-reset busy low", blo, 1);
        chk("post-reset no done", dn, 0);
        run_frame("f0", 8'd0, 1'b0, 24'h002000);

        count = 8'd3; direction = 1'b1;
        @(negedge clk);
        chk("f3 rise", dout, 1'b1);
        run_frame("f3", 8'd3, 1'b1, 24'h200000);
        act = 0;
        repeat (100) begin
            if (busy !== 1'b0 || dout !== 1'b0) act++;
            @(negedge clk);
        end
        chk("idle hold", act, 0);

        direction = 1'b0;
        @(negedge clk);
        chk("f3b rise", dout, 1'b1);
        count = 8'd4;
        run_frame("f3b", 8'd3, 1'b0, 24'h002000);
        chk("f4 rise", dout, 1'b1);
        run_frame("f4", 8'd4, 1'b0, 24'h002000);

        count = 8'd255; direction = 1'b1;
        @(negedge clk);
        chk("f255 rise", dout, 1'b1);
        run_frame("f255", 8'd255, 1'b1, 24'h200000);
        count = 8'd16;
        @(negedge clk);
        chk("f16 rise", dout, 1'b1);
        run_frame("f16", 8'd16, 1'b1, 24'h200000);
`ifdef WS2812_TRAIL_EN
        chk("f16 trail", cap[15], 24'h000008);
`else
        chk("f16 no trail", cap[15], 24'h000000);
`endif

        count = 8'd5; direction = 1'b0;
        @(negedge clk);
        chk("f5 rise", dout, 1'b1);
        repeat (2690) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst dout", dout, 1'b0);
        chk("mid rst busy", busy, 1'b1);
        rst = 1'b0;
        wait_rise(zeros, blo, dn);
        chk("mid rst gap", zeros, 3600);
        chk("mid rst no done", dn, 0);
        run_frame("f5", 8'd5, 1'b0, 24'h002000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ws2812_ring_display.md
Name: ws2812_ring_display

Overview:
- Downstream consumer of the quadrature-decoder stage: takes the 8-bit encoder `count` and `direction` and drives a WS2812 LED ring over a single-wire serial output.
- One LED marks the encoder position. Its colour shows the last rotation direction.
- A frame is sent only when the displayed value changes, plus once after reset.
- Sits between the decoder and the `dout` pad on the up5k.

Parameters:
- LED_BITS, 4, log2 of ring size; NUM_LEDS = 1<<LED_BITS.
- T0H, 5, clocks dout stays high for a 0 bit (12 MHz: 417 ns).
- T1H, 10, clocks dout stays high for a 1 bit (833 ns).
- T_BIT, 15, total clocks per bit (1.25 us); must be > T1H.
- RESET_CYCLES, 3600, clocks of dout low for the latch gap (300 us).
- CW_COLOR, 24'h200000, GRB colour of the lit LED when direction=1.
- CCW_COLOR, 24'h002000, GRB colour of the lit LED when direction=0.
- BG_COLOR, 24'h000000, GRB colour of all other LEDs.
- TRAIL_COLOR, 24'h000008, GRB colour of the trail LED (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- count  in  8  encoder position from the decoder
- direction  in  1  last rotation direction from the decoder (1 = increment)
- dout  out  1  WS2812 serial data
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse at the end of each frame's latch gap

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: dout=0, busy=1, frame_done=0, state=GAP, gap counter=0, snapshot={0,8'h00}, first_frame flag=1.
  - rst asserted mid-frame: dout is 0 the next cycle and the full gap restarts.
- States: GAP, IDLE, HIGH, LOW.
- GAP:
  - dout=0 for exactly RESET_CYCLES clocks, then go to IDLE.
  - frame_done pulses on the GAP->IDLE cycle, except for the post-reset gap.
- IDLE:
  - If first_frame=1, or {direction,count} != snapshot: in that cycle T, latch snapshot <= {direction,count}, clear first_frame, set led_idx=0 and bit_idx=23, go to HIGH.
  - Otherwise stay in IDLE: dout=0, busy=0.
- Lit index: L = snapshot count[LED_BITS-1:0]. Count wrap 255->0 therefore maps naturally onto the ring.
- Per-LED colour:
  - led_idx==L: CW_COLOR if the snapshot direction=1, else CCW_COLOR.
  - All others: BG_COLOR.
  - Colour is selected when each LED begins.
- Bit timing:
  - HIGH: dout=1 for T1H clocks if the current bit=1, else T0H clocks; then go to LOW.
  - LOW: dout=0 for the remaining T_BIT minus high-time clocks.
  - The first bit's dout rises at cycle T+1.
  - Bits go MSB first (bit 23 = G7). There is no gap between bits or between LEDs.
- Sequencing:
  - After bit 0 of an LED, move to the next LED.
  - After bit 0 of LED NUM_LEDS-1, go to GAP.
  - Frame = NUM_LEDS*24*T_BIT clocks, then RESET_CYCLES.
- Input changes during HIGH/LOW/GAP do not affect the frame in flight. They are detected on the first IDLE cycle after the gap, so no update is lost.
- Counters are sized from the parameters.
  - Bit-timer width: clog2(T_BIT).
  - Gap-timer width: clog2(RESET_CYCLES+1).

Optional Feature:
- Macro: WS2812_TRAIL_EN.
- Defined: one trail LED shows TRAIL_COLOR, behind the lit LED relative to motion.
  - Trail index = (L-1) mod NUM_LEDS when direction=1.
  - Trail index = (L+1) mod NUM_LEDS when direction=0.
  - Uses LED_BITS-wide wrap arithmetic. The lit LED wins over the trail (only possible when NUM_LEDS=1).
- Undefined: no trail logic is synthesized; only the lit LED and BG_COLOR are shown. Frame timing is identical in both builds.

Test Plan:
- Reset held, then released with count=0, dir=0 -> busy=1, dout=0 for 3600 clocks, no frame_done. Then first frame: LED0 = 24'h002000, LEDs 1-15 = 0. frame_done pulses 5760+3600 clocks after the frame start.
- Check every pulse of that frame -> high time exactly 5 or 10 clocks, period exactly 15, no inter-LED gap.
- count=3, dir=1 applied in IDLE -> dout rises one cycle later; LED3 decodes as 24'h200000, all others 0. Inputs then held -> busy stays 0, dout stays 0 indefinitely.
- count changed 3->4 mid-frame -> current frame still shows LED3; a new frame showing LED4 starts on the first IDLE cycle after the gap.
- count=255, then 16 (LED_BITS=4) -> lit LED15, then LED0. With WS2812_TRAIL_EN, count=16, dir=1 -> LED15 = 24'h000008.
- rst pulsed at LED 7 bit 12 -> dout=0 next cycle, busy=1, full 3600-clock gap, then a fresh first frame.
